// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem-function sweep checker.
//   state_t     : sequencer states (IDLE, SWEEP, DRAIN, DONE)
//   MAX_EVAL_LAT: deepest evaluator latency the tag pipe is meant to cover
//   MAX_TAG_W   : widest vector tag carried through the result pipe
//   result_t    : one in-flight result slot (valid + vector tag)
package skolem_chk_pkg;

  localparam int MAX_EVAL_LAT = 7;
  localparam int MAX_TAG_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } result_t;

endpackage

// File: rtl/skolem_tag_pipe.sv
// Valid + tag delay line that lines issued vectors up with the evaluator's
// verdicts DEPTH cycles later.
//   clk, rst_n : clock, asynchronous active-low reset (clears valids only)
//   flush      : synchronous clear of every valid bit
//   issue      : slot entering the line this cycle
//   result     : slot leaving the line (DEPTH cycles after issue)
//   empty      : no valid slot is held in the line
// DEPTH = 0 is a straight wire; the line is then always empty.
module skolem_tag_pipe
  import skolem_chk_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  result_t issue,
  output result_t result,
  output logic    empty
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic ctl_unused;
      assign ctl_unused = clk ^ rst_n ^ flush;
      assign result     = issue;
      assign empty      = 1'b1;
    end else begin : g_line
      logic [DEPTH-1:0]     vld_p;
      logic [MAX_TAG_W-1:0] tag_p [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= '0;
        end else if (flush) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= issue.valid;
          for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      // Tags are qualified by vld_p, so they need no reset.
      always_ff @(posedge clk) begin
        tag_p[0] <= issue.tag;
        for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
      end

      assign result.valid = vld_p[DEPTH-1];
      assign result.tag   = tag_p[DEPTH-1];
      assign empty        = ~|vld_p;
    end
  endgenerate

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep sequencer for a Skolem-function evaluator and its oracle.
// Drives every N_IN-bit assignment once, matches the oracle verdicts that
// come back EVAL_LAT cycles later, and reports the mismatch summary.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_i          : begin a sweep (only in IDLE or DONE)
//   abort_i          : cancel and return to IDLE (wins over everything)
//   vec_o/vec_valid_o: assignment presented to the evaluator and oracle
//   exists_i/holds_i : oracle verdicts for the vector issued EVAL_LAT ago
//   busy_o           : SWEEP or DRAIN
//   done_o, pass_o   : sweep finished; pass iff no failing vector
//   fail_cnt_o       : number of failing vectors
//   first_fail_o/_vld_o: first failing vector and its qualifier
// EVAL_LAT is expected to stay within 0..MAX_EVAL_LAT and N_IN within
// 1..MAX_TAG_W.
module skolem_sweep_ctrl
  import skolem_chk_pkg::*;
#(
  parameter int N_IN         = 8,
  parameter int EVAL_LAT     = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  output logic [N_IN-1:0] vec_o,
  output logic            vec_valid_o,
  input  logic            exists_i,
  input  logic            holds_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   fail_cnt_o,
  output logic [N_IN-1:0] first_fail_o,
  output logic            first_fail_vld_o
);

  state_t          state;
  logic [N_IN:0]   next_cnt;   // index of the next vector; MSB set = all issued
  result_t         issue;
  result_t         result;
  logic            pipe_empty;
  logic            fail;
  logic [N_IN-1:0] result_tag;

  assign issue.valid = vec_valid_o;
  assign issue.tag   = MAX_TAG_W'(vec_o);

  skolem_tag_pipe #(
    .DEPTH (EVAL_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (abort_i),
    .issue  (issue),
    .result (result),
    .empty  (pipe_empty)
  );

  assign result_tag = result.tag[N_IN-1:0];

  generate
    if (N_IN < MAX_TAG_W) begin : g_tag_hi
      logic tag_hi_unused;
      assign tag_hi_unused = |result.tag[MAX_TAG_W-1:N_IN];
    end
  endgenerate

  // A vector with no satisfying output at all is a don't-care, not a failure.
  assign fail = result.valid & exists_i & ~holds_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec_o            <= '0;
      vec_valid_o      <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      fail_cnt_o       <= '0;
      first_fail_o     <= '0;
      first_fail_vld_o <= 1'b0;
      next_cnt         <= '0;
    end else if (abort_i) begin
      // Results and statistics are frozen as they stand; the pipe is flushed.
      state       <= IDLE;
      vec_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      if (fail) begin
        fail_cnt_o <= fail_cnt_o + 1'b1;
        if (!first_fail_vld_o) begin
          first_fail_o     <= result_tag;
          first_fail_vld_o <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state            <= SWEEP;
            vec_o            <= '0;
            vec_valid_o      <= 1'b1;
            next_cnt         <= {{N_IN{1'b0}}, 1'b1};
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            fail_cnt_o       <= '0;
            first_fail_o     <= '0;
            first_fail_vld_o <= 1'b0;
          end
        end

        SWEEP: begin
          if (next_cnt[N_IN] || (STOP_ON_FAIL && fail)) begin
            state       <= DRAIN;
            vec_valid_o <= 1'b0;
          end else begin
            vec_o    <= next_cnt[N_IN-1:0];
            next_cnt <= next_cnt + 1'b1;
          end
        end

        DRAIN: begin
          // An empty pipe means no result is being taken this cycle, so the
          // count is already final.
          if (pipe_empty) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (fail_cnt_o == '0);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
module tb_skolem_sweep_ctrl;

  // Instance 0: EVAL_LAT=2, no stop; 1: EVAL_LAT=2, stop on fail; 2: EVAL_LAT=0.
  logic       clk = 1'b0;
  logic       rstn_s   [3];
  logic       start_s  [3];
  logic       abort_s  [3];
  logic [7:0] vec_s    [3];
  logic       vld_s    [3];
  logic       exists_s [3];
  logic       holds_s  [3];
  logic       busy_s   [3];
  logic       done_s   [3];
  logic       pass_s   [3];
  logic [8:0] cnt_s    [3];
  logic [7:0] ff_s     [3];
  logic       ffv_s    [3];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int mode = 0;

  typedef struct {
    int         dut;
    logic [7:0] v;
  } vexp_t;

  typedef struct {
    int   dut;
    logic pass;
    int   cnt;
    int   ff;
    logic ffv;
    int   done_cyc;
  } rexp_t;

  vexp_t vq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  skolem_sweep_ctrl #(.N_IN(8), .EVAL_LAT(2), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk(clk), .rst_n(rstn_s[0]), .start_i(start_s[0]), .abort_i(abort_s[0]),
    .vec_o(vec_s[0]), .vec_valid_o(vld_s[0]), .exists_i(exists_s[0]), .holds_i(holds_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .pass_o(pass_s[0]), .fail_cnt_o(cnt_s[0]),
    .first_fail_o(ff_s[0]), .first_fail_vld_o(ffv_s[0]));

  skolem_sweep_ctrl #(.N_IN(8), .EVAL_LAT(2), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst_n(rstn_s[1]), .start_i(start_s[1]), .abort_i(abort_s[1]),
    .vec_o(vec_s[1]), .vec_valid_o(vld_s[1]), .exists_i(exists_s[1]), .holds_i(holds_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .pass_o(pass_s[1]), .fail_cnt_o(cnt_s[1]),
    .first_fail_o(ff_s[1]), .first_fail_vld_o(ffv_s[1]));

  skolem_sweep_ctrl #(.N_IN(8), .EVAL_LAT(0), .STOP_ON_FAIL(1'b0)) u_lat0 (
    .clk(clk), .rst_n(rstn_s[2]), .start_i(start_s[2]), .abort_i(abort_s[2]),
    .vec_o(vec_s[2]), .vec_valid_o(vld_s[2]), .exists_i(exists_s[2]), .holds_i(holds_s[2]),
    .busy_o(busy_s[2]), .done_o(done_s[2]), .pass_o(pass_s[2]), .fail_cnt_o(cnt_s[2]),
    .first_fail_o(ff_s[2]), .first_fail_vld_o(ffv_s[2]));

  // Oracle model: mode 0 all good, 1 holds=0 at 5A/C3, 2 exists=0 everywhere,
  // 3 holds=0 at 10/11.
  function automatic logic f_ex(int m, logic [7:0] t);
    return (m == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic f_ho(int m, logic [7:0] t);
    case (m)
      1:       return !(t == 8'h5A || t == 8'hC3);
      2:       return 1'b0;
      3:       return !(t == 8'h10 || t == 8'h11);
      default: return 1'b1;
    endcase
  endfunction

  // Two-cycle history of each EVAL_LAT=2 instance's vector.
  logic [7:0] h1 [2];
  logic [7:0] h2 [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      h1[d] <= vec_s[d];
      h2[d] <= h1[d];
    end
  end

  assign exists_s[0] = f_ex(mode, h2[0]);
  assign holds_s[0]  = f_ho(mode, h2[0]);
  assign exists_s[1] = f_ex(mode, h2[1]);
  assign holds_s[1]  = f_ho(mode, h2[1]);
  assign exists_s[2] = f_ex(mode, vec_s[2]);
  assign holds_s[2]  = f_ho(mode, vec_s[2]);

  task automatic chk(string name, int act, int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic note_fail(string name, int act, int req);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic check_reset(int d);
    chk("rst_vec", int'(vec_s[d]), 0);
    chk("rst_vld", int'(vld_s[d]), 0);
    chk("rst_busy", int'(busy_s[d]), 0);
    chk("rst_done", int'(done_s[d]), 0);
    chk("rst_pass", int'(pass_s[d]), 0);
    chk("rst_cnt", int'(cnt_s[d]), 0);
    chk("rst_ff", int'(ff_s[d]), 0);
    chk("rst_ffv", int'(ffv_s[d]), 0);
  endtask

  // Monitor: every live vector and every done_o rise is checked against the queues.
  logic done_prev [3];
  always @(negedge clk) begin
    vexp_t e;
    rexp_t r;
    for (int d = 0; d < 3; d++) begin
      if (vld_s[d] === 1'b1) begin
        if (vq.size() == 0) begin
          note_fail("vec_unexpected", int'(vec_s[d]), -1);
        end else if (vq[0].dut != d) begin
          note_fail("vec_wrong_dut", d, vq[0].dut);
        end else begin
          e = vq.pop_front();
          chk("vec", int'(vec_s[d]), int'(e.v));
        end
      end
      if (done_s[d] === 1'b1 && done_prev[d] !== 1'b1) begin
        if (rq.size() == 0 || rq[0].dut != d) begin
          note_fail("done_unexpected", d, -1);
        end else begin
          r = rq.pop_front();
          chk("pass", int'(pass_s[d]), int'(r.pass));
          chk("fail_cnt", int'(cnt_s[d]), r.cnt);
          chk("first_fail", int'(ff_s[d]), r.ff);
          chk("first_fail_vld", int'(ffv_s[d]), int'(r.ffv));
          chk("busy_at_done", int'(busy_s[d]), 0);
          chk("vecs_left_at_done", vq.size(), 0);
          if (r.done_cyc >= 0) chk("done_cycle", cyc, r.done_cyc);
        end
      end
      done_prev[d] = done_s[d];
    end
  end

  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pushes the expected stream (vectors 0..nvec-1) and summary, then pulses start.
  task automatic run_sweep(int d, int m, int nvec, logic ep, int ecnt, int eff,
                           logic effv, int done_ofs);
    rexp_t r;
    mode = m;
    for (int k = 0; k < nvec; k++) vq.push_back('{dut: d, v: 8'(k)});
    r = '{dut: d, pass: ep, cnt: ecnt, ff: eff, ffv: effv,
          done_cyc: (done_ofs < 0) ? -1 : cyc + done_ofs};
    rq.push_back(r);
    start_s[d] = 1'b1;
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (rq.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rq.size() != 0) note_fail("done_timeout", n, budget);
    rq.delete();
    vq.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    for (int d = 0; d < 3; d++) begin
      rstn_s[d]  = 1'b0;
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rstn_s[d] = 1'b1;

    // All good: start at cycle 10, vectors on 11..266, done at 270.
    wait_until(10);
    run_sweep(0, 0, 256, 1'b1, 0, 0, 1'b0, 260);
    wait_done(400);

    // Two failing tags; first is 0x5A.
    run_sweep(0, 1, 256, 1'b0, 2, 'h5A, 1'b1, 260);
    wait_done(400);

    // Don't-care everywhere, with a stray start mid-sweep that must be ignored.
    run_sweep(0, 2, 256, 1'b1, 0, 0, 1'b0, 260);
    repeat (50) @(posedge clk);
    #1;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    wait_done(400);

    // Stop on first fail: last vector 0x12, both in-flight fails counted.
    run_sweep(1, 3, 19, 1'b0, 2, 'h10, 1'b1, -1);
    wait_done(100);

    // Abort together with start while vector 100 is live.
    t = cyc;
    mode = 1;
    for (int k = 0; k <= 100; k++) vq.push_back('{dut: 0, v: 8'(k)});
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    wait_until(t + 101);
    abort_s[0] = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_s[0] = 1'b0;
    start_s[0] = 1'b0;
    @(negedge clk);
    chk("abort_vld", int'(vld_s[0]), 0);
    chk("abort_busy", int'(busy_s[0]), 0);
    chk("abort_done", int'(done_s[0]), 0);
    chk("abort_cnt_kept", int'(cnt_s[0]), 1);
    chk("abort_ff_kept", int'(ff_s[0]), 'h5A);
    chk("abort_ffv_kept", int'(ffv_s[0]), 1);
    chk("abort_vecs_left", vq.size(), 0);
    repeat (3) @(negedge clk);
    chk("abort_still_idle", int'(busy_s[0]), 0);
    @(posedge clk);
    #1;
    run_sweep(0, 0, 256, 1'b1, 0, 0, 1'b0, 260);
    wait_done(400);

    // EVAL_LAT=0 instance: reset mid-sweep, then a full sweep, done at T+258.
    t = cyc;
    mode = 0;
    for (int k = 0; k < 50; k++) vq.push_back('{dut: 2, v: 8'(k)});
    start_s[2] = 1'b1;
    @(posedge clk);
    #1;
    start_s[2] = 1'b0;
    wait_until(t + 51);
    rstn_s[2] = 1'b0;
    @(negedge clk);
    check_reset(2);
    chk("rst_vecs_left", vq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn_s[2] = 1'b1;
    @(posedge clk);
    #1;
    run_sweep(2, 0, 256, 1'b1, 0, 0, 1'b0, 258);
    wait_done(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
